// File: rtl/tile_bram_manager.sv
// Tile store split into one bank per tile row: writes commit one row per cycle, reads fetch a whole tile.
// Optional: define TILE_BRAM_RANGE_CHK_EN to drop out-of-range selects and pulse O_ERR.
module tile_bram_manager #(
    parameter int D_W     = 8,
    parameter int TILE_R  = 16,
    parameter int TILE_C  = 16,
    parameter int NUM_MAT = 4,
    parameter int LINE_N  = 64,
    parameter int COL_N   = 8,
    parameter int RD_LAT  = 2
) (
    input  logic                                     I_CLK,
    input  logic                                     I_RST_N,
    input  logic                                     I_RD_ENA,
    input  logic                                     I_WR_ENA,
    input  logic [$clog2(NUM_MAT)-1:0]               I_SEL_MAT,
    input  logic [$clog2(LINE_N)-1:0]                I_SEL_LINE,
    input  logic [$clog2(COL_N)-1:0]                 I_SEL_COL,
    input  logic [0:TILE_R-1][0:TILE_C-1][D_W-1:0]   I_MAT,
    output logic                                     O_VLD,
    output logic [0:TILE_R-1][0:TILE_C-1][D_W-1:0]   O_MAT,
    output logic                                     O_WR_DONE,
    output logic                                     O_BUSY,
    output logic                                     O_ERR
);
    localparam int MW    = $clog2(NUM_MAT);
    localparam int LW    = $clog2(LINE_N);
    localparam int CW    = $clog2(COL_N);
    localparam int DEPTH = NUM_MAT * LINE_N * COL_N;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW    = (TILE_R > 1) ? $clog2(TILE_R) : 1;
    localparam logic [3:0] RD_LAST = (RD_LAT >= 2) ? 4'(RD_LAT - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ROW, DONE} state_t;

    state_t                                 state_q, state_d;
    logic                                   op_wr_q;
    logic [AW-1:0]                          addr_q, req_addr, rd_addr;
    logic [3:0]                             cnt_q;
    logic [RW-1:0]                          row_q;
    logic [0:TILE_R-1][0:TILE_C-1][D_W-1:0] stage_q;
    logic                                   req, sel_ok, acc, acc_wr, acc_rd;
    logic                                   rd_fire, wr_en;
    logic [MW-1:0]                          mat_eff;
    logic [LW-1:0]                          line_eff;
    logic [CW-1:0]                          col_eff;

    always_comb begin
`ifdef TILE_BRAM_RANGE_CHK_EN
        sel_ok   = (32'(I_SEL_MAT) < NUM_MAT) && (32'(I_SEL_LINE) < LINE_N) &&
                   (32'(I_SEL_COL) < COL_N);
        mat_eff  = I_SEL_MAT;
        line_eff = I_SEL_LINE;
        col_eff  = I_SEL_COL;
`else
        sel_ok   = 1'b1;
        mat_eff  = MW'(32'(I_SEL_MAT) % NUM_MAT);
        line_eff = LW'(32'(I_SEL_LINE) % LINE_N);
        col_eff  = CW'(32'(I_SEL_COL) % COL_N);
`endif
        req      = (state_q == IDLE) && (I_RD_ENA || I_WR_ENA);
        acc      = req && sel_ok;
        acc_wr   = acc && I_WR_ENA;
        acc_rd   = acc && !I_WR_ENA;
        req_addr = AW'((32'(mat_eff) * LINE_N + 32'(line_eff)) * COL_N + 32'(col_eff));
    end

    // With a one-cycle latency the banks are read on the accepting edge itself.
    always_comb begin
        if (RD_LAT == 1) begin
            rd_fire = acc_rd;
            rd_addr = req_addr;
        end else begin
            rd_fire = (state_q == RD_WAIT) && (cnt_q == RD_LAST);
            rd_addr = addr_q;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= IDLE;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                op_wr_q <= acc_wr;
                addr_q  <= req_addr;
                cnt_q   <= '0;
                row_q   <= '0;
            end else begin
                if (state_q == RD_WAIT) cnt_q <= cnt_q + 4'd1;
                if (state_q == WR_ROW)  row_q <= row_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc_wr)      state_d = WR_ROW;
                else if (acc_rd) state_d = (RD_LAT == 1) ? DONE : RD_WAIT;
            end
            RD_WAIT: if (rd_fire) state_d = DONE;
            WR_ROW:  if (row_q == RW'(TILE_R - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        O_BUSY    = (state_q != IDLE);
        O_VLD     = (state_q == DONE) && !op_wr_q;
        O_WR_DONE = (state_q == DONE) && op_wr_q;
        wr_en     = (state_q == WR_ROW);
    end

    // Staging decouples the committed tile from I_MAT after acceptance.
    always_ff @(posedge I_CLK) begin
        if (acc_wr) stage_q <= I_MAT;
    end

`ifdef TILE_BRAM_RANGE_CHK_EN
    logic err_q;
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) err_q <= 1'b0;
        else          err_q <= req && !sel_ok;
    end
    assign O_ERR = err_q;
`else
    assign O_ERR = 1'b0;
`endif

    for (genvar r = 0; r < TILE_R; r++) begin : g_bank
        logic [0:TILE_C-1][D_W-1:0] mem [DEPTH];
        logic [0:TILE_C-1][D_W-1:0] rd_q;

        always_ff @(posedge I_CLK) begin
            if (wr_en && row_q == RW'(r)) mem[addr_q] <= stage_q[r];
        end

        always_ff @(posedge I_CLK or negedge I_RST_N) begin
            if (!I_RST_N)     rd_q <= '0;
            else if (rd_fire) rd_q <= mem[rd_addr];
        end

        assign O_MAT[r] = rd_q;
    end
endmodule

// File: tb/tb_tile_bram_manager.sv
// Directed bench for tile_bram_manager: vector table of requests plus reset-interrupt sequences.
module tb_tile_bram_manager;
    localparam int D_W = 8, TR = 16, TC = 16, NM = 3, LN = 64, CN = 8, RL = 2;
    localparam int MW = $clog2(NM), LW = $clog2(LN), CW = $clog2(CN);
`ifdef TILE_BRAM_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef logic [0:TR-1][0:TC-1][D_W-1:0] tile_t;
    typedef struct {
        bit wr; bit rd; int m; int l; int c; int kind; int seed; bit intr;
        int exp_done; int exp_vld; int exp_err; int em;
    } vec_t;

    logic          clk = 1'b0, rst_n = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [MW-1:0] sm = '0;
    logic [LW-1:0] sl = '0;
    logic [CW-1:0] sc = '0;
    tile_t         imat = '0, omat;
    logic          vld, done, busy, err;

    int    checks = 0, errors = 0;
    tile_t model [int];
    tile_t last_rd = '0;

    always #5 clk = ~clk;

    tile_bram_manager #(.D_W(D_W), .TILE_R(TR), .TILE_C(TC), .NUM_MAT(NM),
                        .LINE_N(LN), .COL_N(CN), .RD_LAT(RL)) dut (
        .I_CLK(clk), .I_RST_N(rst_n), .I_RD_ENA(rd), .I_WR_ENA(wr),
        .I_SEL_MAT(sm), .I_SEL_LINE(sl), .I_SEL_COL(sc), .I_MAT(imat),
        .O_VLD(vld), .O_MAT(omat), .O_WR_DONE(done), .O_BUSY(busy), .O_ERR(err));

    function automatic tile_t pat(int kind, int seed);
        tile_t t;
        for (int i = 0; i < TR; i++)
            for (int j = 0; j < TC; j++)
                t[i][j] = (kind == 0) ? D_W'(i * 16 + j + seed) : D_W'(seed);
        return t;
    endfunction

    function automatic int key(int m, int l, int c);
        return (m * LN + l) * CN + c;
    endfunction

    function automatic vec_t mk(bit w, bit r, int m, int l, int c, int kind, int seed,
                                bit intr, int ed, int ev, int ee, int em);
        vec_t v;
        v.wr = w; v.rd = r; v.m = m; v.l = l; v.c = c; v.kind = kind; v.seed = seed;
        v.intr = intr; v.exp_done = ed; v.exp_vld = ev; v.exp_err = ee; v.em = em;
        return v;
    endfunction

    task automatic chk_int(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, act, exp);
        end
    endtask

    task automatic chk_tile(string name, tile_t act, tile_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < TR; i++)
                for (int j = 0; j < TC; j++)
                    if (act[i][j] !== exp[i][j]) begin
                        $display("FAIL %s elem[%0d][%0d] got %0h exp %0h", name, i, j,
                                 act[i][j], exp[i][j]);
                        return;
                    end
        end
    endtask

    // Drive one request, then watch exactly up to the expected completion cycle.
    task automatic run(string tag, vec_t v);
        tile_t d;
        tile_t got;
        int    fin, win;
        int    done_at, done_n, vld_at, vld_n, err_at, err_n, busy_bad;
        d = pat(v.kind, v.seed);
        got = '0;
        done_at = 0; done_n = 0; vld_at = 0; vld_n = 0; err_at = 0; err_n = 0; busy_bad = 0;
        fin = (v.exp_done != 0) ? v.exp_done : v.exp_vld;
        win = (fin > 2) ? fin : 2;
        @(negedge clk);
        wr = v.wr; rd = v.rd; sm = MW'(v.m); sl = LW'(v.l); sc = CW'(v.c); imat = d;
        if (v.wr && v.exp_done != 0) model[key(v.em, v.l, v.c)] = d;
        for (int k = 1; k <= win; k++) begin
            @(negedge clk);
            if (done) begin done_n++; if (done_at == 0) done_at = k; end
            if (vld)  begin vld_n++;  if (vld_at == 0)  vld_at = k; got = omat; end
            if (err)  begin err_n++;  if (err_at == 0)  err_at = k; end
            if (busy !== (k <= fin)) busy_bad++;
            if (k == 1) begin wr = 1'b0; rd = 1'b0; imat = ~d; end
            if (v.intr && k == 3) begin
                wr = 1'b1; rd = 1'b1; sm = '0; sl = LW'(3); sc = CW'(1); imat = '1;
            end
            if (v.intr && k == 4) begin wr = 1'b0; rd = 1'b0; end
        end
        chk_int({tag, " done_cyc"}, done_at, v.exp_done);
        chk_int({tag, " done_cnt"}, done_n, (v.exp_done != 0) ? 1 : 0);
        chk_int({tag, " vld_cyc"}, vld_at, v.exp_vld);
        chk_int({tag, " vld_cnt"}, vld_n, (v.exp_vld != 0) ? 1 : 0);
        chk_int({tag, " err_cyc"}, err_at, v.exp_err);
        chk_int({tag, " busy_bad"}, busy_bad, 0);
        if (v.exp_vld != 0) begin
            last_rd = model[key(v.em, v.l, v.c)];
            chk_tile({tag, " rd_data"}, got, last_rd);
        end else begin
            chk_tile({tag, " omat_hold"}, omat, last_rd);
        end
    endtask

    vec_t tbl [15];
    tile_t d, merged;
    int    dn, vn;

    initial begin
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 'h00, 0, 17, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        tbl[2]  = mk(1, 0, 2, 63, 7, 0, 'h40, 0, 17, 0, 0, 2);
        tbl[3]  = mk(0, 1, 2, 63, 7, 0, 0, 0, 0, 2, 0, 2);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        tbl[5]  = mk(1, 0, 0, 3, 1, 1, 'h3C, 0, 17, 0, 0, 0);
        tbl[6]  = mk(1, 0, 0, 1, 1, 0, 'h07, 1, 17, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 3, 1, 0, 0, 0, 0, 2, 0, 0);
        tbl[8]  = mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 2, 0, 0);
        tbl[9]  = mk(1, 1, 1, 5, 3, 1, 'hA5, 0, 17, 0, 0, 1);
        tbl[10] = mk(0, 1, 1, 5, 3, 0, 0, 0, 0, 2, 0, 1);
        tbl[11] = mk(1, 0, 3, 0, 0, 1, 'h5A, 0, CHK ? 0 : 17, 0, CHK ? 1 : 0, 0);
        tbl[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        tbl[13] = mk(0, 1, 3, 0, 0, 0, 0, 0, 0, CHK ? 0 : 2, CHK ? 1 : 0, 0);
        tbl[14] = mk(0, 1, 1, 5, 3, 0, 0, 0, 0, 2, 0, 1);

        repeat (2) @(negedge clk);
        chk_int("rst vld", vld, 0);
        chk_int("rst done", done, 0);
        chk_int("rst busy", busy, 0);
        chk_int("rst err", err, 0);
        chk_tile("rst omat", omat, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run($sformatf("v%0d", i), tbl[i]);
        chk_tile("a5 const", last_rd, pat(1, 'hA5));

        // Reset during a write: rows 0..3 committed, the rest keep the old tile.
        run("old", mk(1, 0, 0, 2, 2, 1, 'h11, 0, 17, 0, 0, 0));
        d = pat(0, 'h80);
        @(negedge clk);
        wr = 1'b1; sm = '0; sl = LW'(2); sc = CW'(2); imat = d;
        dn = 0; vn = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin wr = 1'b0; imat = ~d; end
        end
        rst_n = 1'b0;
        #1;
        chk_int("mw busy", busy, 0);
        chk_int("mw done", done, 0);
        chk_tile("mw omat", omat, '0);
        last_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dn++;
            if (vld) vn++;
        end
        chk_int("mw no_done", dn, 0);
        chk_int("mw no_vld", vn, 0);
        merged = pat(1, 'h11);
        for (int r = 0; r < 4; r++) merged[r] = d[r];
        model[key(0, 2, 2)] = merged;
        run("mw rd", mk(0, 1, 0, 2, 2, 0, 0, 0, 0, 2, 0, 0));

        // Reset during a read: no valid pulse afterwards.
        @(negedge clk);
        rd = 1'b1; sm = '0; sl = LW'(2); sc = CW'(2);
        @(negedge clk);
        rd = 1'b0; rst_n = 1'b0;
        last_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        vn = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (vld) vn++;
        end
        chk_int("mr no_vld", vn, 0);
        chk_tile("mr omat", omat, '0);
        run("mr top", mk(0, 1, 2, 63, 7, 0, 0, 0, 0, 2, 0, 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tile_bram_manager.md
TILE_BRAM_MANAGER -- requirements
Module: tile_bram_manager

Interface
REQ-001 Parameter D_W, default 8: element width in bits.
REQ-002 Parameter TILE_R, default 16: rows per tile.
REQ-003 Parameter TILE_C, default 16: columns per tile.
REQ-004 Parameter NUM_MAT, default 4: number of stored matrices.
REQ-005 Parameter LINE_N, default 64: tile lines per matrix.
REQ-006 Parameter COL_N, default 8: tile columns per matrix.
REQ-007 Parameter RD_LAT, default 2 (legal range 1..8): read latency in cycles.
REQ-008 Port I_CLK, input, 1 bit: the only clock; all logic on its rising edge.
REQ-009 Port I_RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-010 Port I_RD_ENA, input, 1 bit: tile read request.
REQ-011 Port I_WR_ENA, input, 1 bit: tile write request.
REQ-012 Port I_SEL_MAT, input, $clog2(NUM_MAT) bits: matrix select.
REQ-013 Port I_SEL_LINE, input, $clog2(LINE_N) bits: tile-line select.
REQ-014 Port I_SEL_COL, input, $clog2(COL_N) bits: tile-column select.
REQ-015 Port I_MAT, input, D_W bits x [0:TILE_R-1][0:TILE_C-1]: write tile.
REQ-016 Port O_VLD, output, 1 bit: one-cycle read-data-valid pulse.
REQ-017 Port O_MAT, output, D_W bits x [0:TILE_R-1][0:TILE_C-1]: read tile.
REQ-018 Port O_WR_DONE, output, 1 bit: one-cycle write-complete pulse.
REQ-019 Port O_BUSY, output, 1 bit: request in progress; new requests ignored.
REQ-020 Port O_ERR, output, 1 bit: one-cycle out-of-range request pulse.

Function
REQ-021 Storage SHALL be NUM_MAT x LINE_N x COL_N tiles of TILE_R x TILE_C elements.
REQ-022 FSM states SHALL be IDLE, RD_WAIT, WR_ROW, DONE.
REQ-023 A request SHALL be accepted only in IDLE with O_BUSY low; requests arriving while busy SHALL be dropped with no side effect.
REQ-024 Simultaneous I_RD_ENA and I_WR_ENA at acceptance: the write SHALL win and the read SHALL be dropped.
REQ-025 Read accepted at cycle t: IDLE->RD_WAIT, then O_MAT = addressed tile and O_VLD = 1 at cycle t+RD_LAT only.
REQ-026 O_MAT SHALL hold its value until the next read completes.
REQ-027 Write accepted at cycle t: I_MAT and the address SHALL be captured into a staging register at t.
REQ-028 Write SHALL commit one row per cycle, row r at cycle t+1+r (WR_ROW), then enter DONE.
REQ-029 O_WR_DONE SHALL pulse at cycle t+TILE_R+1; the FSM SHALL then return to IDLE.
REQ-030 O_BUSY SHALL be high from cycle t+1 through the O_VLD or O_WR_DONE cycle inclusive; a new request is acceptable the following cycle.
REQ-031 I_MAT changes after acceptance SHALL NOT affect the tile being written.
REQ-032 The tile with the highest address (NUM_MAT-1, LINE_N-1, COL_N-1) SHALL be accessible without wrap or aliasing.

Reset
REQ-033 On I_RST_N low, outputs SHALL reset to O_VLD=0, O_WR_DONE=0, O_BUSY=0, O_ERR=0, O_MAT all zero, and FSM to IDLE, asynchronously.
REQ-034 Tile storage SHALL NOT be reset.
REQ-035 On reset mid-write, rows already committed SHALL remain and O_WR_DONE SHALL NOT pulse; on reset mid-read, O_VLD SHALL NOT pulse.

Configuration
REQ-036 Macro TILE_BRAM_RANGE_CHK_EN defined: a request with I_SEL_MAT>=NUM_MAT, I_SEL_LINE>=LINE_N or I_SEL_COL>=COL_N SHALL be dropped, O_ERR SHALL pulse the cycle after the request, and O_BUSY SHALL stay low.
REQ-037 Macro TILE_BRAM_RANGE_CHK_EN undefined: out-of-range select fields SHALL be reduced modulo their limit, and O_ERR SHALL be tied 0.

Verification
REQ-038 Write tile (0,0,0) with element [i][j]=i*16+j, then read it -> O_WR_DONE at t+17, O_VLD at t'+2, O_MAT identical.
REQ-039 I_RD_ENA and I_WR_ENA pulsed during a write (O_BUSY high) -> no O_VLD, no extra O_WR_DONE, and storage unchanged apart from the accepted write.
REQ-040 Simultaneous RD and WR in IDLE to (1,5,3) with data 8'hA5 -> one O_WR_DONE, no O_VLD; a later read returns all 8'hA5.
REQ-041 Assert I_RST_N low at cycle t+5 of a write, then read the tile back -> rows 0..3 hold new data, rows 4..15 hold old data, no O_WR_DONE.
REQ-042 With NUM_MAT=3 and the macro defined, request I_SEL_MAT=3 -> O_ERR pulse, no access; macro undefined -> access goes to matrix 0.
REQ-043 Write then read tile (NUM_MAT-1, LINE_N-1, COL_N-1) and tile (0,0,0) with distinct data -> both read back intact.
